// File: rtl/uart_tx_feeder_pkg.sv
// Shared defaults and the feeder FSM encoding for the UART transmit front end.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_DEPTH          = 16;
  localparam int DEFAULT_ACCEPT_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host push side plus UART load side of the feeder, bundled as one interface.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = uart_pkg::DEFAULT_DEPTH
);

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    full;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    clr_overflow;
  logic                    enable;
  logic                    busy;
  logic                    accept_err;
  logic                    ld_tx_data;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_enable;
  logic                    tx_empty;

  // master is everything around the feeder (host and UART); slave is the feeder
  modport master (
    output wr_en, wr_data, clr_overflow, enable, tx_empty,
    input  full, level, overflow, busy, accept_err, ld_tx_data, tx_data, tx_enable
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow, enable, tx_empty,
    output full, level, overflow, busy, accept_err, ld_tx_data, tx_data, tx_enable
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; level and full are registered post-edge occupancy.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = uart_pkg::DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic [DATA_WIDTH-1:0]  head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level_next;
  logic                  do_push;
  logic                  do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge
  assign do_push = push & ~full;
  assign do_pop  = pop & (level != '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + 1'b1;
    end else if (do_pop && !do_push) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == FULL_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops bytes from the FIFO and hands them to the UART with a one-cycle load strobe,
// then follows tx_empty until the UART has accepted and finished each byte.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int ACCEPT_TIMEOUT = DEFAULT_ACCEPT_TIMEOUT
) (
  input logic            txclk,
  input logic            reset,
  uart_tx_feeder_if.slave bus
);

  localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACCEPT_TIMEOUT - 1);

  feeder_state_t         state;
  feeder_state_t         state_next;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  start_load;
  logic                  timeout;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (txclk),
    .reset   (reset),
    .push    (bus.wr_en),
    .pop     (start_load),
    .wr_data (bus.wr_data),
    .head    (fifo_head),
    .level   (bus.level),
    .full    (bus.full)
  );

  assign start_load = (state == IDLE) & bus.enable & (bus.level != '0) & bus.tx_empty;
  // Timeout fires on the last permitted WAIT_ACCEPT cycle if the UART still reports empty
  assign timeout    = (state == WAIT_ACCEPT) & bus.tx_empty & (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge txclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (start_load) state_next = LOAD;
      LOAD:        state_next = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (!bus.tx_empty) state_next = WAIT_DONE;
        else if (timeout)  state_next = IDLE;
      end
      WAIT_DONE:   if (bus.tx_empty) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ld_tx_data = (state == LOAD);
    bus.busy       = (state != IDLE) | (bus.level != '0);
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      wait_cnt       <= '0;
      bus.tx_data    <= '0;
      bus.tx_enable  <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.accept_err <= 1'b0;
    end else begin
      bus.tx_enable <= bus.enable;
      if (start_load) bus.tx_data <= fifo_head;

      if (state == LOAD)             wait_cnt <= '0;
      else if (state == WAIT_ACCEPT) wait_cnt <= wait_cnt + 1'b1;

      if (bus.wr_en && bus.full)  bus.overflow <= 1'b1;
      else if (bus.clr_overflow)  bus.overflow <= 1'b0;

      if (timeout) bus.accept_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple UART model that answers each load strobe.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic txclk = 1'b0;
  logic reset;
  logic uart_auto   = 1'b0;
  logic man_empty   = 1'b1;
  logic model_empty = 1'b1;
  int   low_cnt     = 0;
  bit   pend        = 1'b0;
  int   errors;
  int   checks;

  always #5 txclk = ~txclk;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_if ();

  assign bus_if.tx_empty = uart_auto ? model_empty : man_empty;

  uart_tx_feeder #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .ACCEPT_TIMEOUT (4)
  ) dut (
    .txclk (txclk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // UART model: one cycle after seeing a strobe, tx_empty drops for 10 cycles
  always @(negedge txclk) begin
    if (!uart_auto) begin
      model_empty = 1'b1;
      pend        = 1'b0;
      low_cnt     = 0;
    end else begin
      if (low_cnt > 0) begin
        low_cnt = low_cnt - 1;
        if (low_cnt == 0) model_empty = 1'b1;
      end else if (pend) begin
        pend        = 1'b0;
        model_empty = 1'b0;
        low_cnt     = 10;
      end
      if (bus_if.ld_tx_data) pend = 1'b1;
    end
  end

  task automatic wait_strobe(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge txclk);
      if (bus_if.ld_tx_data) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.enable = 1'b1;
    repeat (2) @(negedge txclk);
    checks++; if (bus_if.level !== 5'd0) begin errors++; $display("[TB] FAIL rst_level: got %0d expected 0", bus_if.level); end
    checks++; if (bus_if.full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full: got %b expected 0", bus_if.full); end
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %b expected 0", bus_if.overflow); end
    checks++; if (bus_if.accept_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_accept_err: got %b expected 0", bus_if.accept_err); end
    checks++; if (bus_if.ld_tx_data !== 1'b0) begin errors++; $display("[TB] FAIL rst_ld: got %b expected 0", bus_if.ld_tx_data); end
    checks++; if (bus_if.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_tx_data: got %h expected 00", bus_if.tx_data); end
    checks++; if (bus_if.tx_enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_enable: got %b expected 0", bus_if.tx_enable); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", bus_if.busy); end
    reset = 1'b0;
    @(negedge txclk);
    checks++; if (bus_if.tx_enable !== 1'b1) begin errors++; $display("[TB] FAIL tx_enable_follow: got %b expected 1", bus_if.tx_enable); end
  endtask

  task automatic test_single_byte();
    uart_auto = 1'b1;
    bus_if.enable = 1'b1;
    repeat (2) @(negedge txclk);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hA5;
    @(negedge txclk);
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.level !== 5'd1) begin errors++; $display("[TB] FAIL single_level_push: got %0d expected 1", bus_if.level); end
    checks++; if (bus_if.ld_tx_data !== 1'b0) begin errors++; $display("[TB] FAIL single_ld_early: got %b expected 0", bus_if.ld_tx_data); end
    @(negedge txclk);
    checks++; if (bus_if.ld_tx_data !== 1'b1) begin errors++; $display("[TB] FAIL single_ld_latency: got %b expected 1", bus_if.ld_tx_data); end
    checks++; if (bus_if.tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_tx_data: got %h expected a5", bus_if.tx_data); end
    checks++; if (bus_if.level !== 5'd0) begin errors++; $display("[TB] FAIL single_level_pop: got %0d expected 0", bus_if.level); end
    @(negedge txclk);
    checks++; if (bus_if.ld_tx_data !== 1'b0) begin errors++; $display("[TB] FAIL single_ld_width: got %b expected 0", bus_if.ld_tx_data); end
    repeat (20) @(negedge txclk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_tx_data_hold: got %h expected a5", bus_if.tx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [3];
    int n;
    int adj;
    logic prev_ld;
    n = 0; adj = 0; prev_ld = 1'b0;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    for (int c = 0; c < 120; c++) begin
      @(negedge txclk);
      if (bus_if.ld_tx_data) begin
        if (prev_ld) adj++;
        if (n < 3) got[n] = bus_if.tx_data;
        n++;
      end
      prev_ld = bus_if.ld_tx_data;
      bus_if.wr_en   = (c < 3);
      bus_if.wr_data = 8'(c + 1);
    end
    bus_if.wr_en = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", n); end
    checks++; if (got[0] !== 8'h01) begin errors++; $display("[TB] FAIL b2b_byte0: got %h expected 01", got[0]); end
    checks++; if (got[1] !== 8'h02) begin errors++; $display("[TB] FAIL b2b_byte1: got %h expected 02", got[1]); end
    checks++; if (got[2] !== 8'h03) begin errors++; $display("[TB] FAIL b2b_byte2: got %h expected 03", got[2]); end
    checks++; if (adj !== 0) begin errors++; $display("[TB] FAIL b2b_adjacent: got %0d expected 0", adj); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.accept_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept_err: got %b expected 0", bus_if.accept_err); end
  endtask

  task automatic test_overflow();
    uart_auto = 1'b0;
    bus_if.enable = 1'b0;
    repeat (2) @(negedge txclk);
    for (int i = 0; i < 17; i++) begin
      if (i == 15) begin
        checks++; if (bus_if.full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_at_15: got %b expected 0", bus_if.full); end
      end
      if (i == 16) begin
        checks++; if (bus_if.full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_at_16: got %b expected 1", bus_if.full); end
        checks++; if (bus_if.level !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level_16: got %0d expected 16", bus_if.level); end
        checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", bus_if.overflow); end
      end
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(8'h10 + i);
      @(negedge txclk);
    end
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", bus_if.overflow); end
    checks++; if (bus_if.level !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level_kept: got %0d expected 16", bus_if.level); end
    @(negedge txclk);
    checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus_if.overflow); end
    bus_if.clr_overflow = 1'b1; bus_if.wr_en = 1'b1;
    @(negedge txclk);
    bus_if.clr_overflow = 1'b0; bus_if.wr_en = 1'b0;
    checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_beats_clr: got %b expected 1", bus_if.overflow); end
    bus_if.clr_overflow = 1'b1;
    @(negedge txclk);
    bus_if.clr_overflow = 1'b0;
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", bus_if.overflow); end
    reset = 1'b1;
    @(negedge txclk);
    reset = 1'b0;
  endtask

  task automatic test_accept_timeout();
    uart_auto = 1'b0;
    man_empty = 1'b1;
    bus_if.enable = 1'b1;
    @(negedge txclk);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h55;
    @(negedge txclk);
    bus_if.wr_en = 1'b0;
    @(negedge txclk);
    checks++; if (bus_if.ld_tx_data !== 1'b1) begin errors++; $display("[TB] FAIL tmo_strobe: got %b expected 1", bus_if.ld_tx_data); end
    checks++; if (bus_if.tx_data !== 8'h55) begin errors++; $display("[TB] FAIL tmo_tx_data: got %h expected 55", bus_if.tx_data); end
    repeat (4) @(negedge txclk);
    checks++; if (bus_if.accept_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early: got %b expected 0", bus_if.accept_err); end
    @(negedge txclk);
    checks++; if (bus_if.accept_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag: got %b expected 1", bus_if.accept_err); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle: got %b expected 0", bus_if.busy); end
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h66;
    @(negedge txclk);
    bus_if.wr_en = 1'b0;
    @(negedge txclk);
    checks++; if (bus_if.ld_tx_data !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_strobe: got %b expected 1", bus_if.ld_tx_data); end
    checks++; if (bus_if.tx_data !== 8'h66) begin errors++; $display("[TB] FAIL tmo_next_data: got %h expected 66", bus_if.tx_data); end
    checks++; if (bus_if.accept_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky: got %b expected 1", bus_if.accept_err); end
    repeat (8) @(negedge txclk);
    reset = 1'b1;
    @(negedge txclk);
    reset = 1'b0;
    checks++; if (bus_if.accept_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_reset_clear: got %b expected 0", bus_if.accept_err); end
  endtask

  task automatic test_reset_mid_transfer();
    bit seen;
    bus_if.enable = 1'b0;
    uart_auto = 1'b1;
    @(negedge txclk);
    for (int i = 0; i < 6; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(8'h61 + i);
      @(negedge txclk);
    end
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.level !== 5'd6) begin errors++; $display("[TB] FAIL mid_level_6: got %0d expected 6", bus_if.level); end
    bus_if.enable = 1'b1;
    wait_strobe(10, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL mid_strobe_timeout: got %b expected 1", seen); end
    checks++; if (bus_if.tx_data !== 8'h61) begin errors++; $display("[TB] FAIL mid_tx_data: got %h expected 61", bus_if.tx_data); end
    repeat (3) @(negedge txclk);
    checks++; if (bus_if.level !== 5'd5) begin errors++; $display("[TB] FAIL mid_level_5: got %0d expected 5", bus_if.level); end
    reset = 1'b1;
    @(negedge txclk);
    reset = 1'b0;
    checks++; if (bus_if.level !== 5'd0) begin errors++; $display("[TB] FAIL mid_rst_level: got %0d expected 0", bus_if.level); end
    checks++; if (bus_if.ld_tx_data !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ld: got %b expected 0", bus_if.ld_tx_data); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_tx_data: got %h expected 00", bus_if.tx_data); end
    bus_if.enable = 1'b0;
    uart_auto = 1'b0;
    repeat (3) @(negedge txclk);
  endtask

  task automatic test_push_pop_same();
    logic [7:0] got [3];
    int n;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(8'h31 + i);
      @(negedge txclk);
    end
    checks++; if (bus_if.level !== 5'd3) begin errors++; $display("[TB] FAIL pp_level_before: got %0d expected 3", bus_if.level); end
    uart_auto = 1'b1;
    bus_if.enable = 1'b1;
    bus_if.wr_data = 8'h34;
    @(negedge txclk);
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.level !== 5'd3) begin errors++; $display("[TB] FAIL pp_level_same: got %0d expected 3", bus_if.level); end
    checks++; if (bus_if.ld_tx_data !== 1'b1) begin errors++; $display("[TB] FAIL pp_strobe: got %b expected 1", bus_if.ld_tx_data); end
    checks++; if (bus_if.tx_data !== 8'h31) begin errors++; $display("[TB] FAIL pp_first: got %h expected 31", bus_if.tx_data); end
    for (int c = 0; c < 100; c++) begin
      @(negedge txclk);
      if (bus_if.ld_tx_data) begin
        if (n < 3) got[n] = bus_if.tx_data;
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL pp_count: got %0d expected 3", n); end
    checks++; if (got[0] !== 8'h32) begin errors++; $display("[TB] FAIL pp_byte1: got %h expected 32", got[0]); end
    checks++; if (got[1] !== 8'h33) begin errors++; $display("[TB] FAIL pp_byte2: got %h expected 33", got[1]); end
    checks++; if (got[2] !== 8'h34) begin errors++; $display("[TB] FAIL pp_byte3: got %h expected 34", got[2]); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL pp_busy_end: got %b expected 0", bus_if.busy); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.wr_data = '0;
    bus_if.clr_overflow = 1'b0;
    bus_if.enable = 1'b0;
    $display("[TB] starting uart_tx_feeder bench");
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_accept_timeout();
    test_reset_mid_transfer();
    test_push_pop_same();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
